circ_fifo: RTL

Parametrised circular FIFO with valid/ready handshakes on both sides, first-word-fall-through read data, occupancy count, almost-full flag and synchronous flush. It replaces the shift-register queue between the decode/rename stages and the issue/dispatch buffers, where it absorbs back-pressure and is flushed on branch mispredict. Storage is a RAM-style array indexed by wrapping read/write pointers, so entries never shift.

---
 rtl/circ_fifo.sv | 117 +++++++++++
 1 files changed

// File: rtl/circ_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : circ_fifo
//  Purpose  : Circular FIFO with valid/ready handshakes on both sides,
//             first-word-fall-through read data, occupancy count,
//             almost-full flag and synchronous flush.
//  Options  : CIRC_FIFO_BYPASS_EN - when defined, an empty FIFO forwards
//             in_data to out_data combinationally in the same cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module circ_fifo #(
   parameter int WIDTH        = 32,
   parameter int DEPTH        = 8,
   parameter int AFULL_THRESH = DEPTH - 2
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       flush,
   input  logic                       in_valid,
   input  logic [WIDTH-1:0]           in_data,
   output logic                       in_ready,
   output logic                       out_valid,
   output logic [WIDTH-1:0]           out_data,
   input  logic                       out_ready,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       full,
   output logic                       empty,
   output logic                       almost_full
);

   localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int c_CNT_W = $clog2(DEPTH + 1);

   localparam logic [c_PTR_W-1:0] c_LAST_PTR = c_PTR_W'(DEPTH - 1);
   localparam logic [c_CNT_W-1:0] c_FULL_CNT = c_CNT_W'(DEPTH);
   localparam logic [c_CNT_W-1:0] c_AFULL_CNT = c_CNT_W'(AFULL_THRESH);

   logic [WIDTH-1:0]   r_mem [DEPTH];
   logic [c_PTR_W-1:0] r_wr_ptr;
   logic [c_PTR_W-1:0] r_rd_ptr;
   logic [c_CNT_W-1:0] r_count;

   logic w_empty;
   logic w_full;
   logic w_push;
   logic w_pop;

   // Explicit wrap so non-power-of-two depths never index past the array.
   function automatic logic [c_PTR_W-1:0] f_next_ptr(input logic [c_PTR_W-1:0] ptr);
      return (ptr == c_LAST_PTR) ? '0 : ptr + 1'b1;
   endfunction

   // Status is derived purely from the occupancy register.
   assign w_empty     = (r_count == '0);
   assign w_full      = (r_count == c_FULL_CNT);
   assign empty       = w_empty;
   assign full        = w_full;
   assign almost_full = (r_count >= c_AFULL_CNT);
   assign in_ready    = !w_full;
   assign count       = r_count;

   // A pop only consumes a stored entry; a bypassed word never touches the array.
   assign w_pop = !w_empty && out_ready && !flush;

`ifdef CIRC_FIFO_BYPASS_EN
   logic w_bypass;

   // Empty FIFO presents the incoming word directly; flush kills the forward.
   assign w_bypass  = w_empty && in_valid && !flush;
   assign out_valid = !w_empty || w_bypass;
   assign out_data  = w_empty ? in_data : r_mem[r_rd_ptr];
   // A word taken on the bypass path in the same cycle is not stored.
   assign w_push    = in_valid && !w_full && !flush && !(w_bypass && out_ready);
`else
   assign out_valid = !w_empty;
   assign out_data  = r_mem[r_rd_ptr];
   assign w_push    = in_valid && !w_full && !flush;
`endif

   // Storage array: written on push only, never reset.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= in_data;
      end
   end

   // Read/write pointers: flush returns both to the origin.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else if (flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) r_wr_ptr <= f_next_ptr(r_wr_ptr);
         if (w_pop)  r_rd_ptr <= f_next_ptr(r_rd_ptr);
      end
   end

   // Occupancy: net change of push and pop, cleared by flush.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_count <= '0;
      end else if (flush) begin
         r_count <= '0;
      end else begin
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule
`default_nettype wire
